// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register for a
// 5-stage MIPS pipeline.
//
// Owns the PC and fetches from instruction memory with at most one request
// outstanding. A one-entry holding buffer catches a response that lands while
// ID is stalled. A branch flush redirects the PC, bubbles IF/ID and discards
// any in-flight response.
//
// Handshake (instruction memory):
//   A request is accepted in a cycle where imem_req and imem_gnt are both 1.
//   The response is a single-cycle imem_rvalid pulse. It arrives in order, no
//   earlier than one cycle after the grant. imem_req drops as soon as a request
//   is accepted, so there is never more than one request in flight.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 hold PC and IF/ID (load-use hazard)
//   branch_flush          redirect to branch_target and bubble IF/ID
//   branch_target         redirect address
//   imem_req/imem_addr    fetch request and its address (the PC register)
//   imem_gnt              request accepted
//   imem_rvalid/rdata     instruction response
//   if_id_valid/instr     IF/ID contents; instr is 0 (NOP) while invalid
//   if_id_pc/pc_plus4     address of if_id_instr and that address + 4
//   dbg_state             FSM state (0 FETCH, 1 WAIT, 2 DISCARD)
//   dbg_hold_valid        holding buffer occupied
//
// Optional build macro FETCH_PERF_CNT_EN adds the following wrapping 32-bit
// counters: perf_stall_cnt, perf_flush_cnt and perf_discard_cnt.

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [1:0]  dbg_state,
  output logic        dbg_hold_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;

  logic req_fire;
  logic deliver;

  assign req_fire = imem_req && imem_gnt;
  // A response that arrives in WAIT is only delivered when no flush is
  // killing it in the same cycle.
  assign deliver  = (state_q == S_WAIT) && imem_rvalid && !branch_flush;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (req_fire) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)       state_d = S_FETCH;
        else if (branch_flush) state_d = S_DISCARD;
      end
      S_DISCARD: if (imem_rvalid) state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // FSM: outputs. rst_n gates the request so nothing issues during reset.
  always_comb begin
    imem_req  = rst_n && (state_q == S_FETCH) && !hold_valid_q && !branch_flush;
    dbg_state = state_q;
  end

  // PC and outstanding-request address
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (branch_flush)  pc_d = branch_target;
    else if (req_fire) pc_d = pc_q + 32'd4;
    if (req_fire) req_pc_d = pc_q;
  end

  // IF/ID register and holding buffer
  always_comb begin
    if_id_valid_d    = if_id_valid_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    hold_valid_d     = hold_valid_q;
    hold_instr_d     = hold_instr_q;
    hold_pc_d        = hold_pc_q;
    if (branch_flush) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = 32'h0;
      hold_valid_d  = 1'b0;
    end else if (stall) begin
      if (deliver) begin
        hold_valid_d = 1'b1;
        hold_instr_d = imem_rdata;
        hold_pc_d    = req_pc_q;
      end
    end else if (hold_valid_q) begin
      if_id_valid_d    = 1'b1;
      if_id_instr_d    = hold_instr_q;
      if_id_pc_d       = hold_pc_q;
      if_id_pc_plus4_d = hold_pc_q + 32'd4;
      hold_valid_d     = 1'b0;
    end else if (deliver) begin
      if_id_valid_d    = 1'b1;
      if_id_instr_d    = imem_rdata;
      if_id_pc_d       = req_pc_q;
      if_id_pc_plus4_d = req_pc_q + 32'd4;
    end else begin
      // Bubble: the PC fields keep their last values.
      if_id_valid_d = 1'b0;
      if_id_instr_d = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      req_pc_q         <= RESET_PC;
      hold_valid_q     <= 1'b0;
      hold_instr_q     <= 32'h0;
      hold_pc_q        <= 32'h0;
      if_id_valid_q    <= 1'b0;
      if_id_instr_q    <= 32'h0;
      if_id_pc_q       <= 32'h0;
      if_id_pc_plus4_q <= 32'h0;
    end else begin
      pc_q             <= pc_d;
      req_pc_q         <= req_pc_d;
      hold_valid_q     <= hold_valid_d;
      hold_instr_q     <= hold_instr_d;
      hold_pc_q        <= hold_pc_d;
      if_id_valid_q    <= if_id_valid_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = if_id_valid_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign dbg_hold_valid = hold_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic        dropped;
  logic [31:0] perf_stall_q, perf_flush_q, perf_discard_q;

  // A response is dropped when a flush kills it in WAIT, or when it arrives
  // in DISCARD.
  assign dropped = imem_rvalid &&
                   (((state_q == S_WAIT) && branch_flush) || (state_q == S_DISCARD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q   <= 32'h0;
      perf_flush_q   <= 32'h0;
      perf_discard_q <= 32'h0;
    end else begin
      if (stall)        perf_stall_q   <= perf_stall_q + 32'd1;
      if (branch_flush) perf_flush_q   <= perf_flush_q + 32'd1;
      if (dropped)      perf_discard_q <= perf_discard_q + 32'd1;
    end
  end

  assign perf_stall_cnt   = perf_stall_q;
  assign perf_flush_cnt   = perf_flush_q;
  assign perf_discard_cnt = perf_discard_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall, branch_flush;
  logic [31:0] branch_target;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
  logic [1:0]  dbg_state;
  logic        dbg_hold_valid;

  // second instance exercising PC wrap-around
  logic        w_gnt, w_rvalid;
  logic [31:0] w_rdata;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr, w_pc, w_pc4;
  logic [1:0]  w_state;
  logic        w_hold;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_flush(branch_flush),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .dbg_state(dbg_state), .dbg_hold_valid(dbg_hold_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .branch_flush(1'b0),
    .branch_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .if_id_valid(w_valid), .if_id_instr(w_instr), .if_id_pc(w_pc),
    .if_id_pc_plus4(w_pc4), .dbg_state(w_state), .dbg_hold_valid(w_hold)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; branch_flush = 1'b0; branch_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    exp_instr_q.delete(); exp_pc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    // take one grant so the FSM leaves FETCH, then reset mid-operation
    @(negedge clk); imem_gnt = 1'b1;
    @(negedge clk); imem_gnt = 1'b0;
    rst_n = 1'b0; #1;
    n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL rst_async_state got %0d exp 0", dbg_state); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    @(negedge clk); #1;
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL rst_addr got %h exp 00000000", imem_addr); end
    n_checks++; if (w_addr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL rst_addr_wrap got %h exp fffffffc", w_addr); end
    n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin n_errors++; $display("FAIL rst_ifid got v=%b i=%h exp v=0 i=0", if_id_valid, if_id_instr); end
    n_checks++; if (if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin n_errors++; $display("FAIL rst_ifid_pc got %h/%h exp 0/0", if_id_pc, if_id_pc_plus4); end
    n_checks++; if (dbg_hold_valid !== 1'b0) begin n_errors++; $display("FAIL rst_hold got %b exp 0", dbg_hold_valid); end
    rst_n = 1'b1; #1;
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL rst_first_req got %b exp 1", imem_req); end
  endtask

  task automatic test_stream();
    logic        pend;
    logic [31:0] pend_addr, next_addr, ei, ep;
    do_reset();
    pend = 1'b0; pend_addr = 32'h0; next_addr = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (if_id_valid !== ((c >= 2) && (c % 2 == 0))) begin n_errors++; $display("FAIL stream_valid_c%0d got %b exp %b", c, if_id_valid, ((c >= 2) && (c % 2 == 0))); end
      if (if_id_valid === 1'b1) begin
        n_checks++;
        if (exp_instr_q.size() == 0) begin n_errors++; $display("FAIL stream_extra got pc %h exp none", if_id_pc); end
        else begin
          ei = exp_instr_q.pop_front(); ep = exp_pc_q.pop_front();
          if (if_id_instr !== ei || if_id_pc !== ep || if_id_pc_plus4 !== ep + 32'd4) begin
            n_errors++; $display("FAIL stream_data got %h/%h/%h exp %h/%h/%h", if_id_instr, if_id_pc, if_id_pc_plus4, ei, ep, ep + 32'd4);
          end
        end
      end
      imem_rvalid = pend; imem_rdata = pend ? pend_addr : 32'h0;
      if (pend) begin exp_instr_q.push_back(pend_addr); exp_pc_q.push_back(pend_addr); end
      pend = 1'b0;
      #1;
      imem_gnt = imem_req;
      if (imem_req === 1'b1) begin
        n_checks++; if (imem_addr !== next_addr) begin n_errors++; $display("FAIL stream_addr got %h exp %h", imem_addr, next_addr); end
        pend = 1'b1; pend_addr = imem_addr; next_addr = next_addr + 32'd4;
      end
    end
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b0;
  endtask

  task automatic test_stall_hold();
    logic [31:0] ei, ep;
    do_reset();
    @(negedge clk); imem_gnt = 1'b1;
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    exp_instr_q.push_back(32'h1111_1111); exp_pc_q.push_back(32'h0);
    // A: first instruction visible, grant addr 4, stall starts
    @(negedge clk); imem_rvalid = 1'b0; imem_gnt = 1'b1; stall = 1'b1;
    ei = exp_instr_q.pop_front(); ep = exp_pc_q.pop_front();
    n_checks++; if (if_id_valid !== 1'b1 || if_id_instr !== ei || if_id_pc !== ep) begin n_errors++; $display("FAIL stall_first got %b/%h/%h exp 1/%h/%h", if_id_valid, if_id_instr, if_id_pc, ei, ep); end
    // B: response arrives while stalled
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C22_0004;
    exp_instr_q.push_back(32'h8C22_0004); exp_pc_q.push_back(32'h4);
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL stall_req_b got %b exp 0", imem_req); end
    n_checks++; if (if_id_instr !== 32'h1111_1111 || if_id_valid !== 1'b1) begin n_errors++; $display("FAIL stall_hold_b got %b/%h exp 1/11111111", if_id_valid, if_id_instr); end
    // C: last stalled cycle
    @(negedge clk); imem_rvalid = 1'b0; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL stall_req_c got %b exp 0", imem_req); end
    n_checks++; if (dbg_hold_valid !== 1'b1) begin n_errors++; $display("FAIL stall_buf_c got %b exp 1", dbg_hold_valid); end
    n_checks++; if (if_id_instr !== 32'h1111_1111 || if_id_pc !== 32'h0) begin n_errors++; $display("FAIL stall_hold_c got %h/%h exp 11111111/0", if_id_instr, if_id_pc); end
    // D: stall released; buffer drains at this edge
    @(negedge clk); stall = 1'b0; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL stall_req_d got %b exp 0", imem_req); end
    n_checks++; if (if_id_instr !== 32'h1111_1111) begin n_errors++; $display("FAIL stall_hold_d got %h exp 11111111", if_id_instr); end
    // E
    @(negedge clk); #1;
    ei = exp_instr_q.pop_front(); ep = exp_pc_q.pop_front();
    n_checks++; if (if_id_valid !== 1'b1 || if_id_instr !== ei || if_id_pc !== ep || if_id_pc_plus4 !== ep + 32'd4) begin n_errors++; $display("FAIL stall_drain got %b/%h/%h/%h exp 1/%h/%h/%h", if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, ei, ep, ep + 32'd4); end
    n_checks++; if (dbg_hold_valid !== 1'b0) begin n_errors++; $display("FAIL stall_buf_e got %b exp 0", dbg_hold_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_errors++; $display("FAIL stall_next_req got %b/%h exp 1/00000008", imem_req, imem_addr); end
  endtask

  task automatic test_flush_wait();
    logic [31:0] ei, ep;
    do_reset();
    @(negedge clk); imem_gnt = 1'b1;
    @(negedge clk); imem_gnt = 1'b0; branch_flush = 1'b1; branch_target = 32'h100; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL fw_req_flush got %b exp 0", imem_req); end
    @(negedge clk); branch_flush = 1'b0; #1;
    n_checks++; if (dbg_state !== 2'd2 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin n_errors++; $display("FAIL fw_discard got st=%0d req=%b addr=%h exp st=2 req=0 addr=00000100", dbg_state, imem_req, imem_addr); end
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); imem_rvalid = 1'b0; #1;
    n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin n_errors++; $display("FAIL fw_dropped got %b/%h exp 0/00000000", if_id_valid, if_id_instr); end
    n_checks++; if (dbg_state !== 2'd0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_errors++; $display("FAIL fw_refetch got st=%0d req=%b addr=%h exp st=0 req=1 addr=00000100", dbg_state, imem_req, imem_addr); end
    imem_gnt = 1'b1;
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2001_0100;
    exp_instr_q.push_back(32'h2001_0100); exp_pc_q.push_back(32'h100);
    @(negedge clk); imem_rvalid = 1'b0;
    ei = exp_instr_q.pop_front(); ep = exp_pc_q.pop_front();
    n_checks++; if (if_id_valid !== 1'b1 || if_id_instr !== ei || if_id_pc !== ep || if_id_pc_plus4 !== ep + 32'd4) begin n_errors++; $display("FAIL fw_target_instr got %b/%h/%h/%h exp 1/%h/%h/%h", if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, ei, ep, ep + 32'd4); end
  endtask

  task automatic test_flush_rvalid();
    do_reset();
    @(negedge clk); imem_gnt = 1'b1;
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    branch_flush = 1'b1; branch_target = 32'h200;
    @(negedge clk); imem_rvalid = 1'b0; branch_flush = 1'b0; #1;
    n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin n_errors++; $display("FAIL fr_bubble got %b/%h exp 0/00000000", if_id_valid, if_id_instr); end
    n_checks++; if (dbg_state !== 2'd0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_errors++; $display("FAIL fr_redirect got st=%0d req=%b addr=%h exp st=0 req=1 addr=00000200", dbg_state, imem_req, imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL fr_no_late got %b exp 0", if_id_valid); end
  endtask

  task automatic test_stall_flush_hold();
    logic [31:0] ei, ep;
    do_reset();
    @(negedge clk); imem_gnt = 1'b1;
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0000;
    exp_instr_q.push_back(32'hAAAA_0000); exp_pc_q.push_back(32'h0);
    @(negedge clk); imem_rvalid = 1'b0; imem_gnt = 1'b1; stall = 1'b1;
    ei = exp_instr_q.pop_front(); ep = exp_pc_q.pop_front();
    n_checks++; if (if_id_valid !== 1'b1 || if_id_instr !== ei || if_id_pc !== ep) begin n_errors++; $display("FAIL sf_first got %b/%h/%h exp 1/%h/%h", if_id_valid, if_id_instr, if_id_pc, ei, ep); end
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk); imem_rvalid = 1'b0; branch_flush = 1'b1; branch_target = 32'h300; #1;
    n_checks++; if (dbg_hold_valid !== 1'b1 || if_id_instr !== 32'hAAAA_0000) begin n_errors++; $display("FAIL sf_before got hold=%b i=%h exp hold=1 i=aaaa0000", dbg_hold_valid, if_id_instr); end
    @(negedge clk); stall = 1'b0; branch_flush = 1'b0; #1;
    n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || dbg_hold_valid !== 1'b0) begin n_errors++; $display("FAIL sf_cleared got v=%b i=%h hold=%b exp 0/00000000/0", if_id_valid, if_id_instr, dbg_hold_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_errors++; $display("FAIL sf_target got %b/%h exp 1/00000300", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL sf_no_drain got %b exp 0", if_id_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk); w_gnt = 1'b1; #1;
    n_checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_first got %b/%h exp 1/fffffffc", w_req, w_addr); end
    @(negedge clk); w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h0BAD_F00D;
    @(negedge clk); w_rvalid = 1'b0; #1;
    n_checks++; if (w_valid !== 1'b1 || w_instr !== 32'h0BAD_F00D || w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0) begin n_errors++; $display("FAIL wrap_ifid got %b/%h/%h/%h exp 1/0badf00d/fffffffc/00000000", w_valid, w_instr, w_pc, w_pc4); end
    n_checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_second got %b/%h exp 1/00000000", w_req, w_addr); end
  endtask

  task automatic test_back_to_back_random();
    logic        pend;
    logic [31:0] pend_addr, next_addr, ei, ep;
    int          cnt;
    do_reset();
    pend = 1'b0; pend_addr = 32'h0; next_addr = 32'h0; cnt = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (if_id_valid === 1'b1) begin
        n_checks++;
        if (exp_instr_q.size() == 0) begin n_errors++; $display("FAIL rnd_extra got pc %h exp none", if_id_pc); end
        else begin
          ei = exp_instr_q.pop_front(); ep = exp_pc_q.pop_front();
          if (if_id_instr !== ei || if_id_pc !== ep || if_id_pc_plus4 !== ep + 32'd4) begin
            n_errors++; $display("FAIL rnd_data got %h/%h/%h exp %h/%h/%h", if_id_instr, if_id_pc, if_id_pc_plus4, ei, ep, ep + 32'd4);
          end
        end
      end
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1; imem_rdata = ~pend_addr;
          exp_instr_q.push_back(~pend_addr); exp_pc_q.push_back(pend_addr);
          pend = 1'b0;
        end else cnt--;
      end
      #1;
      imem_gnt = 1'b0;
      if (imem_req === 1'b1 && c < 60 && $urandom_range(0, 1) == 1) begin
        n_checks++; if (imem_addr !== next_addr) begin n_errors++; $display("FAIL rnd_addr got %h exp %h", imem_addr, next_addr); end
        imem_gnt = 1'b1; pend = 1'b1; pend_addr = imem_addr; next_addr = next_addr + 32'd4;
        cnt = $urandom_range(0, 2);
      end
    end
    n_checks++; if (exp_instr_q.size() != 0) begin n_errors++; $display("FAIL rnd_leftover got %0d exp 0", exp_instr_q.size()); end
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_flush_wait();
    test_flush_rvalid();
    test_stall_flush_hold();
    test_wrap();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
